lut_sweep_reader: RTL and testbench
===================================

LUT_SWEEP_READER -- requirements
Module: lut_sweep_reader

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of cycles each LUT address is held before its response is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  sweep request; sampled only in IDLE.
REQ-005 SHALL have port busy  output  1  high from start acceptance until done.
REQ-006 SHALL have port done  output  1  one-cycle pulse after the last byte handshake.
REQ-007 SHALL have port lut_addr  output  8  address driven to the external combinational 8-in/1-out LUT neuron.
REQ-008 SHALL have port lut_data  input  1  LUT neuron response for lut_addr.
REQ-009 SHALL have port out_data  output  8  packed truth-table byte.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port out_last  output  1  high with out_valid on byte 31 only.

Function
REQ-013 SHALL implement the states IDLE, SAMPLE, EMIT and FIN.
REQ-014 SHALL, in IDLE with start=1, move to SAMPLE with lut_addr=0 and the settle counter loaded with SETTLE_CYCLES.
REQ-015 SHALL hold each lut_addr for exactly SETTLE_CYCLES cycles in SAMPLE and capture lut_data on the final one of those cycles.
REQ-016 SHALL pack bits LSB-first, so bit i of byte k equals the LUT response at address 8k+i, for k=0..31.
REQ-017 SHALL increment lut_addr after each capture and, after the 8th capture of a byte, move to EMIT with out_valid=1 on the next cycle.
REQ-018 SHALL hold out_data, out_last and lut_addr stable in EMIT while out_valid=1 and out_ready=0, with no further sampling.
REQ-019 SHALL complete a byte on the cycle with out_valid=1 and out_ready=1, then return to SAMPLE, or go to FIN if the byte is byte 31.
REQ-020 SHALL wrap lut_addr from 255 to 0 on the final increment, with no extra sample taken.
REQ-021 SHALL, in FIN, assert done for one cycle, deassert busy, and return to IDLE.
REQ-022 SHALL ignore start when not in IDLE, including a start coincident with done.
REQ-023 SHALL take exactly 32*(8*SETTLE_CYCLES+1)+1 cycles from start acceptance to done when out_ready is tied high.
REQ-024 SHALL keep out_valid low outside EMIT and never present a partially packed byte.

Reset
REQ-025 SHALL, on rst_n=0 at any time, immediately force IDLE with busy=0, done=0, out_valid=0, out_last=0, out_data=0 and lut_addr=0.
REQ-026 SHALL discard a sweep interrupted by reset, and SHALL NOT resume it after rst_n returns high.

Configuration
REQ-027 SHALL, when LUT_SWEEP_POPCNT_EN is defined, add output ones_count (9 bits), which counts captured 1s during the sweep, is cleared at start acceptance and on reset, and holds its final value (0..256) from the done cycle until the next start.
REQ-028 SHALL, without LUT_SWEEP_POPCNT_EN, omit the ones_count port and its counter entirely, leaving all other behaviour identical.

Verification
REQ-029 SHALL cover: LUT model returns addr[0], SETTLE_CYCLES=1, out_ready=1 -> 32 bytes of 8'hAA, out_last on byte 31, done 289 cycles after start.
REQ-030 SHALL cover: LUT model returns 1 only at address 8'h99 -> byte 19 = 8'h02 and all other bytes 8'h00; with LUT_SWEEP_POPCNT_EN, ones_count=1 at done.
REQ-031 SHALL cover: out_ready held low 5 cycles on byte 3 -> out_data and lut_addr stable for those cycles, no bits lost, and the byte sequence unchanged.
REQ-032 SHALL cover: SETTLE_CYCLES=3 with the LUT model output delayed by 2 cycles -> correct bytes and done 32*25+1=801 cycles after start.
REQ-033 SHALL cover: rst_n pulsed low mid-byte 10 -> outputs reach reset values asynchronously, and the next start sweeps from address 0 with byte 0 emitted first.
REQ-034 SHALL cover: start asserted while busy and again on the done cycle -> both ignored, with exactly 32 bytes emitted per accepted start.

Source files
------------

// File: rtl/lut_sweep_reader.sv
// lut_sweep_reader
//   Sweeps all 256 addresses of an external combinational 8-in/1-out LUT
//   neuron. Each address is held for SETTLE_CYCLES cycles and the response is
//   captured on the last of them. Responses are packed LSB-first into 32
//   truth-table bytes that leave through a valid/ready stream.
//
// Ports
//   clk        : single clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   start      : sweep request, sampled only while idle
//   busy       : high from start acceptance until done
//   done       : one-cycle pulse after the last byte handshake
//   lut_addr   : address driven to the LUT neuron
//   lut_data   : LUT neuron response for lut_addr
//   out_data   : packed truth-table byte
//   out_valid  : out_data is valid
//   out_ready  : downstream accepts out_data
//   out_last   : high with out_valid on byte 31 only
//   ones_count : (LUT_SWEEP_POPCNT_EN only) number of captured 1s this sweep
//
// Build option
//   LUT_SWEEP_POPCNT_EN : adds the ones_count output and its counter.
//
// state  | meaning
// IDLE   | waiting for start
// SAMPLE | holding lut_addr, settle counter running down to capture
// EMIT   | full byte presented on out_data, waiting for out_ready
// FIN    | done pulse, back to IDLE next cycle

module lut_sweep_reader #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] lut_addr,
  input  logic       lut_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef LUT_SWEEP_POPCNT_EN
  output logic [8:0] ones_count,
`endif
  output logic       out_last
);

  typedef enum logic [1:0] {IDLE, SAMPLE, EMIT, FIN} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] settle_q, settle_d;
  logic [6:0] pack_q, pack_d;
  logic [7:0] data_q, data_d;
  logic       capture;

  // The settle counter reaching 1 marks the final cycle of the hold window.
  assign capture = (state_q == SAMPLE) && (settle_q == 4'd1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    settle_d = settle_q;
    pack_d   = pack_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SAMPLE;
          addr_d   = 8'd0;
          settle_d = SETTLE_LOAD;
        end
      end
      SAMPLE: begin
        if (capture) begin
          // Shift right so the first capture ends up in bit 0.
          pack_d   = {lut_data, pack_q[6:1]};
          addr_d   = addr_q + 8'd1;
          settle_d = SETTLE_LOAD;
          if (addr_q[2:0] == 3'd7) begin
            data_d  = {lut_data, pack_q};
            state_d = EMIT;
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      EMIT: begin
        // addr has already wrapped to 0 while the final byte is presented.
        if (out_ready) begin
          state_d = (addr_q == 8'd0) ? FIN : SAMPLE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 8'd0;
      settle_q <= 4'd0;
      pack_q   <= 7'd0;
      data_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      settle_q <= settle_d;
      pack_q   <= pack_d;
      data_q   <= data_d;
    end
  end

  assign busy      = (state_q == SAMPLE) || (state_q == EMIT);
  assign done      = (state_q == FIN);
  assign out_valid = (state_q == EMIT);
  assign out_last  = (state_q == EMIT) && (addr_q == 8'd0);
  assign out_data  = data_q;
  assign lut_addr  = addr_q;

`ifdef LUT_SWEEP_POPCNT_EN
  logic [8:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if ((state_q == IDLE) && start) begin
      ones_d = 9'd0;
    end else if (capture) begin
      ones_d = ones_q + 9'(lut_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 9'd0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_lut_sweep_reader.sv
// Testbench for lut_sweep_reader: two instances (SETTLE_CYCLES=1 with a
// combinational LUT model, SETTLE_CYCLES=3 with a 2-cycle delayed LUT model)
// driven from a shared truth table and checked against bytes computed
// directly from that table.

module tb_lut_sweep_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int n_assert = 0;
  int n_fail   = 0;

  bit lut_tab [256];

  // instance a: SETTLE_CYCLES = 1
  logic       start_a = 1'b0;
  logic       busy_a, done_a, out_valid_a, out_last_a, lut_data_a;
  logic [7:0] lut_addr_a, out_data_a;
  logic       out_ready_a = 1'b1;
  logic [8:0] ones_a;

  // instance b: SETTLE_CYCLES = 3, delayed LUT
  logic       start_b = 1'b0;
  logic       busy_b, done_b, out_valid_b, out_last_b, lut_data_b;
  logic [7:0] lut_addr_b, out_data_b;
  logic       out_ready_b = 1'b1;
  logic [8:0] ones_b;
  logic       dly1_b = 1'b0, dly2_b = 1'b0;

  logic [7:0] got_a [$];
  bit         last_a [$];
  logic [7:0] got_b [$];
  bit         last_b [$];

  int         stall_byte = -1;
  int         stall_len  = 5;
  int         stall_cnt  = 0;
  logic [7:0] hold_data, hold_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign lut_data_a = lut_tab[lut_addr_a];

  always @(posedge clk) begin
    dly1_b <= lut_tab[lut_addr_b];
    dly2_b <= dly1_b;
  end
  assign lut_data_b = dly2_b;

  lut_sweep_reader #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .lut_addr(lut_addr_a), .lut_data(lut_data_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
`ifdef LUT_SWEEP_POPCNT_EN
    .ones_count(ones_a),
`endif
    .out_last(out_last_a)
  );

  lut_sweep_reader #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .lut_addr(lut_addr_b), .lut_data(lut_data_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
`ifdef LUT_SWEEP_POPCNT_EN
    .ones_count(ones_b),
`endif
    .out_last(out_last_b)
  );

`ifndef LUT_SWEEP_POPCNT_EN
  assign ones_a = 9'd0;
  assign ones_b = 9'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instance a monitor: decides out_ready for the coming edge, then logs
  // the byte if that edge completes a handshake. Also stalls one byte.
  always @(negedge clk) begin
    if (out_valid_a) begin
      if (stall_byte == got_a.size() && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          hold_data = out_data_a;
          hold_addr = lut_addr_a;
        end else begin
          chk("stall_data", out_data_a, hold_data);
          chk("stall_addr", lut_addr_a, hold_addr);
        end
        out_ready_a = 1'b0;
        stall_cnt++;
      end else begin
        if (stall_cnt > 0 && stall_byte == got_a.size()) begin
          chk("stall_release_data", out_data_a, hold_data);
          chk("stall_release_addr", lut_addr_a, hold_addr);
        end
        out_ready_a = 1'b1;
        got_a.push_back(out_data_a);
        last_a.push_back(out_last_a);
      end
    end else begin
      out_ready_a = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (out_valid_b) begin
      got_b.push_back(out_data_b);
      last_b.push_back(out_last_b);
    end
  end

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = lut_tab[8*k + i];
    return b;
  endfunction

  function automatic int exp_ones();
    int n = 0;
    for (int a = 0; a < 256; a++) n += int'(lut_tab[a]);
    return n;
  endfunction

  task automatic set_tab(input int mode);
    for (int a = 0; a < 256; a++) begin
      case (mode)
        0:       lut_tab[a] = a[0];
        1:       lut_tab[a] = (a == 8'h99);
        default: lut_tab[a] = $urandom_range(1, 0) == 1;
      endcase
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] q [$], input bit l [$]);
    int n;
    chk({tag, "_count"}, q.size(), 32);
    n = (q.size() < 32) ? q.size() : 32;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), q[k], exp_byte(k));
      chk($sformatf("%s_last%0d", tag, k), l[k], (k == 31));
    end
  endtask

  // Called aligned to a falling edge; lat is measured from the cycle start
  // is presented to the cycle done is high.
  task automatic sweep_a(input bit hold, output int lat);
    bit seen = 0;
    int t0;
    got_a.delete();
    last_a.delete();
    lat = -1;
    t0 = cyc;
    start_a = 1'b1;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      if (!hold) start_a = 1'b0;
      if (done_a) begin
        seen = 1;
        lat = cyc - t0;
        chk("busy_low_at_done", busy_a, 0);
`ifdef LUT_SWEEP_POPCNT_EN
        chk("ones_count_a", ones_a, exp_ones());
`endif
      end
    end
    chk("done_seen_a", seen, 1);
    if (hold) begin
      @(posedge clk);
      #1 start_a = 1'b0;
    end
    @(negedge clk);
    chk("done_one_cycle_a", done_a, 0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    bit  any_busy;
    int  t0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_last", out_last_a, 0);
    chk("rst_data", out_data_a, 8'h00);
    chk("rst_addr", lut_addr_a, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // addr[0] LUT -> all bytes AA
    set_tab(0);
    sweep_a(0, lat);
    chk("lat_s1", lat, 289);
    check_bytes("aa", got_a, last_a);
    for (int k = 0; k < 32 && k < got_a.size(); k++) chk("aa_const", got_a[k], 8'hAA);

    // single one at 0x99
    set_tab(1);
    sweep_a(0, lat);
    check_bytes("x99", got_a, last_a);
    if (got_a.size() > 19) chk("x99_byte19", got_a[19], 8'h02);

    // random table with a 5-cycle stall on byte 3
    set_tab(2);
    stall_byte = 3;
    stall_cnt = 0;
    sweep_a(0, lat);
    check_bytes("stall", got_a, last_a);
    chk("stall_cycles", stall_cnt, 5);
    chk("lat_stall", lat, 289 + 5);
    stall_byte = -1;

    // SETTLE_CYCLES=3 with delayed LUT
    set_tab(2);
    got_b.delete();
    last_b.delete();
    seen = 0;
    lat = -1;
    t0 = cyc;
    start_b = 1'b1;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        seen = 1;
        lat = cyc - t0;
`ifdef LUT_SWEEP_POPCNT_EN
        chk("ones_count_b", ones_b, exp_ones());
`endif
      end
    end
    chk("done_seen_b", seen, 1);
    chk("lat_s3", lat, 801);
    check_bytes("s3", got_b, last_b);

    // start held through the whole sweep and the done cycle
    set_tab(2);
    sweep_a(1, lat);
    chk("lat_hold", lat, 289);
    any_busy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy_a || out_valid_a) any_busy = 1;
    end
    check_bytes("hold", got_a, last_a);
    chk("no_restart", any_busy, 0);

    // reset mid-byte 10
    set_tab(2);
    got_a.delete();
    last_a.delete();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 2000 && got_a.size() < 10; c++) @(negedge clk);
    chk("reach_byte10", got_a.size(), 10);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_valid", out_valid_a, 0);
    chk("arst_last", out_last_a, 0);
    chk("arst_data", out_data_a, 8'h00);
    chk("arst_addr", lut_addr_a, 8'h00);
`ifdef LUT_SWEEP_POPCNT_EN
    chk("arst_ones", ones_a, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    any_busy = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy_a || out_valid_a) any_busy = 1;
    end
    chk("no_resume", any_busy, 0);
    chk("no_bytes_after_rst", got_a.size(), 10);
    sweep_a(0, lat);
    chk("lat_after_rst", lat, 289);
    check_bytes("post_rst", got_a, last_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
